// File: rtl/instr_sequencer_decoder.sv
// Instruction sequencer/decoder: latches one 16-bit instruction through a
// valid/ready handshake. It then walks the register-file/ALU datapath through
// operand reads, execute and write-back. The register numbers and enables for
// each step are generated here. Illegal encodings are flagged.
module instr_sequencer_decoder #(
  parameter int DATA_W       = 16,
  parameter bit STALL_EN     = 1'b1,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              step_ready,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              rd_en,
  output logic              rd_port,
  output logic              asel_zero,
  output logic              exec_en,
  output logic              status_en,
  output logic              wr_en,
  output logic              wr_src,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] ir_reg;

  logic advance;
  logic is_movimm;
  logic is_movreg;
  logic is_cmp;
  logic is_mvn;

  // The first step depends on the {opcode, op} of the incoming instruction.
  // Any encoding that is not listed goes straight to ERR.
  function automatic state_t first_step(input logic [4:0] opc_op);
    case (opc_op)
      5'b110_10: first_step = WR;    // MOV Rn,#imm8
      5'b110_00: first_step = RD_B;  // MOV Rd,Rm{,sh}
      5'b101_00: first_step = RD_A;  // ADD
      5'b101_10: first_step = RD_A;  // AND
      5'b101_01: first_step = RD_A;  // CMP
      5'b101_11: first_step = RD_B;  // MVN
      default:   first_step = ERR;
    endcase
  endfunction

  // State and instruction register. The IR loads only when an instruction is
  // accepted in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ir_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && in_valid)
        ir_reg <= instr;
    end
  end

  // Field decode from the latched IR.
  assign opcode    = ir_reg[15:13];
  assign op        = ir_reg[12:11];
  assign ALUop     = ir_reg[12:11];
  assign sximm5    = {{(DATA_W-5){ir_reg[4]}}, ir_reg[4:0]};
  assign sximm8    = {{(DATA_W-8){ir_reg[7]}}, ir_reg[7:0]};
  assign is_movimm = (ir_reg[15:11] == 5'b110_10);
  assign is_movreg = (ir_reg[15:11] == 5'b110_00);
  assign is_cmp    = (ir_reg[15:11] == 5'b101_01);
  assign is_mvn    = (ir_reg[15:11] == 5'b101_11);
  // Only ALU instructions and MOV-reg use the shifter field. In MOV-imm those
  // bits belong to imm8.
  assign shift     = (ir_reg[15:13] == 3'b101 || is_movreg) ? ir_reg[4:3] : 2'b00;
  // Without stall support, every datapath step lasts one cycle.
  assign advance   = (STALL_EN == 1'b0) || step_ready;

  // Next-state and per-step datapath controls, driven from the state register and IR.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    rd_en      = 1'b0;
    rd_port    = 1'b0;
    asel_zero  = 1'b0;
    exec_en    = 1'b0;
    status_en  = 1'b0;
    wr_en      = 1'b0;
    wr_src     = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = first_step(instr[15:11]);
      end
      RD_A: begin
        rd_en   = 1'b1;
        rd_port = 1'b0;
        readnum = ir_reg[10:8];
        if (advance)
          state_next = RD_B;
      end
      RD_B: begin
        rd_en   = 1'b1;
        rd_port = 1'b1;
        readnum = ir_reg[2:0];
        if (advance)
          state_next = EXEC;
      end
      EXEC: begin
        exec_en   = 1'b1;
        status_en = is_cmp;
        asel_zero = is_movreg || is_mvn;
        if (advance)
          state_next = is_cmp ? DONE : WR;
      end
      WR: begin
        wr_en    = 1'b1;
        wr_src   = is_movimm;
        writenum = is_movimm ? ir_reg[10:8] : ir_reg[7:5];
        if (advance)
          state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        illegal = 1'b1;
        if (ILLEGAL_HALT == 1'b0)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer_decoder.sv
// Testbench for instr_sequencer_decoder. The reference model expands every
// instruction into its list of datapath steps. Each cycle, the expected
// outputs are built from that step and the instruction fields.
module tb_instr_sequencer_decoder;

  typedef enum int {K_IDLE, K_RDA, K_RDB, K_EXEC, K_WR, K_DONE, K_ERR} kind_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] instr;
  logic        step_ready;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [1:0]  op, ALUop, shift;
  logic [15:0] sximm5, sximm8;
  logic [2:0]  readnum, writenum;
  logic        rd_en, rd_port, asel_zero, exec_en, status_en, wr_en, wr_src, done, illegal;

  // Second instance: halting on illegal, no stalls, narrow immediates.
  logic        in_valid2;
  logic [15:0] instr2;
  logic        step_ready2;
  logic        in_ready2;
  logic [2:0]  opcode2;
  logic [1:0]  op2, aluop2, shift2;
  logic [11:0] sximm5_2, sximm8_2;
  logic [2:0]  readnum2, writenum2;
  logic        rd_en2, rd_port2, asel_zero2, exec_en2, status_en2, wr_en2, wr_src2, done2, illegal2;

  int checks = 0;
  int failures = 0;
  logic [15:0] model_ir = 16'h0000;
  kind_t seq_q[$];

  always #5 clk = ~clk;

  instr_sequencer_decoder #(.DATA_W(16), .STALL_EN(1'b1), .ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .step_ready(step_ready), .opcode(opcode), .op(op), .ALUop(ALUop), .shift(shift),
    .sximm5(sximm5), .sximm8(sximm8), .readnum(readnum), .writenum(writenum),
    .rd_en(rd_en), .rd_port(rd_port), .asel_zero(asel_zero), .exec_en(exec_en),
    .status_en(status_en), .wr_en(wr_en), .wr_src(wr_src), .done(done), .illegal(illegal)
  );

  instr_sequencer_decoder #(.DATA_W(12), .STALL_EN(1'b0), .ILLEGAL_HALT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .instr(instr2),
    .step_ready(step_ready2), .opcode(opcode2), .op(op2), .ALUop(aluop2), .shift(shift2),
    .sximm5(sximm5_2), .sximm8(sximm8_2), .readnum(readnum2), .writenum(writenum2),
    .rd_en(rd_en2), .rd_port(rd_port2), .asel_zero(asel_zero2), .exec_en(exec_en2),
    .status_en(status_en2), .wr_en(wr_en2), .wr_src(wr_src2), .done(done2), .illegal(illegal2)
  );

  // Observed outputs of the main instance, packed in a fixed order.
  function automatic logic [56:0] observe();
    return {in_ready, rd_en, rd_port, readnum, exec_en, status_en, asel_zero, wr_en,
            wr_src, writenum, done, illegal, shift, opcode, op, ALUop, sximm5, sximm8};
  endfunction

  // Expected outputs for one step of an instruction, in the same order as observe().
  function automatic logic [56:0] model(input kind_t k, input logic [15:0] ins);
    int opc, opv, rn, rd, rm, v5, v8;
    logic movimm, movreg, cmp, mvn;
    logic [2:0] rnum, wnum;
    logic [1:0] sh;
    logic [15:0] s5, s8;
    opc = int'(ins[15:13]); opv = int'(ins[12:11]);
    rn = int'(ins[10:8]); rd = int'(ins[7:5]); rm = int'(ins[2:0]);
    movimm = (opc == 6 && opv == 2);
    movreg = (opc == 6 && opv == 0);
    cmp    = (opc == 5 && opv == 1);
    mvn    = (opc == 5 && opv == 3);
    v5 = int'(ins[4:0]); if (v5 >= 16)  v5 = v5 - 32;
    v8 = int'(ins[7:0]); if (v8 >= 128) v8 = v8 - 256;
    s5 = 16'(v5); s8 = 16'(v8);
    sh = (opc == 5 || movreg) ? ins[4:3] : 2'b00;
    rnum = (k == K_RDA) ? 3'(rn) : (k == K_RDB) ? 3'(rm) : 3'd0;
    wnum = (k == K_WR) ? (movimm ? 3'(rn) : 3'(rd)) : 3'd0;
    return {k == K_IDLE, (k == K_RDA || k == K_RDB), k == K_RDB, rnum,
            k == K_EXEC, (k == K_EXEC && cmp), (k == K_EXEC && (movreg || mvn)),
            k == K_WR, (k == K_WR && movimm), wnum, k == K_DONE, k == K_ERR,
            sh, ins[15:13], ins[12:11], ins[12:11], s5, s8};
  endfunction

  // The step list each instruction class goes through.
  task automatic build_seq(input logic [15:0] ins);
    seq_q.delete();
    case (ins[15:11])
      5'b110_10: begin seq_q.push_back(K_WR); end
      5'b110_00, 5'b101_11: begin
        seq_q.push_back(K_RDB); seq_q.push_back(K_EXEC); seq_q.push_back(K_WR);
      end
      5'b101_00, 5'b101_10: begin
        seq_q.push_back(K_RDA); seq_q.push_back(K_RDB); seq_q.push_back(K_EXEC);
        seq_q.push_back(K_WR);
      end
      5'b101_01: begin
        seq_q.push_back(K_RDA); seq_q.push_back(K_RDB); seq_q.push_back(K_EXEC);
      end
      default: ;
    endcase
    if (seq_q.size() == 0) seq_q.push_back(K_ERR);
    else                   seq_q.push_back(K_DONE);
  endtask

  task automatic check_vec(input string tag, input logic [56:0] obs, input logic [56:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one instruction from IDLE to its last step. Every cycle is checked
  // against the model. Mode 0: step_ready=1. Mode 1: random step_ready.
  // Mode 2: three stall cycles in RD_B. Returns the cycle number, counted
  // from the accept edge, in which done was first seen.
  task automatic run_instr(input logic [15:0] ins, input int mode, output int lat);
    int idx, cyc, stalls;
    build_seq(ins);
    @(negedge clk);
    check_vec("idle_before_accept", observe(), model(K_IDLE, model_ir));
    in_valid = 1'b1; instr = ins; step_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; instr = 16'($urandom);
    model_ir = ins;
    idx = 0; cyc = 0; stalls = 0; lat = -1;
    while (idx < seq_q.size() && cyc < 60) begin
      @(negedge clk);
      cyc++;
      check_vec($sformatf("ins=%h step=%0d cyc=%0d", ins, int'(seq_q[idx]), cyc),
                observe(), model(seq_q[idx], ins));
      if (seq_q[idx] == K_DONE && lat < 0) lat = cyc;
      if (mode == 1)
        step_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && seq_q[idx] == K_RDB && stalls < 3) begin
        step_ready = 1'b0; stalls++;
      end else
        step_ready = 1'b1;
      @(posedge clk);
      if (step_ready || seq_q[idx] == K_DONE || seq_q[idx] == K_ERR) idx++;
    end
    if (idx < seq_q.size()) check_int("sequence_timeout", cyc, -1);
    $display("txn instr=%h mode=%0d cycles=%0d done_cycle=%0d", ins, mode, cyc, lat);
  endtask

  initial begin
    int lat, cyc;
    logic [15:0] r;
    logic [4:0] legal [6];
    legal[0] = 5'b110_10; legal[1] = 5'b110_00; legal[2] = 5'b101_00;
    legal[3] = 5'b101_10; legal[4] = 5'b101_01; legal[5] = 5'b101_11;

    reset = 1'b0; in_valid = 1'b0; instr = 16'hFFFF; step_ready = 1'b1;
    in_valid2 = 1'b0; instr2 = 16'h0000; step_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("reset_state", observe(), model(K_IDLE, 16'h0000));
    reset = 1'b1;

    // Reset asserted while an ADD is in EXEC.
    @(negedge clk);
    in_valid = 1'b1; instr = 16'hA148; step_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_vec("add_in_exec", observe(), model(K_EXEC, 16'hA148));
    #2 reset = 1'b0;
    #1 check_vec("async_reset_mid_add", observe(), model(K_IDLE, 16'h0000));
    @(negedge clk);
    check_vec("reset_next_cycle", observe(), model(K_IDLE, 16'h0000));
    reset = 1'b1;
    model_ir = 16'h0000;
    $display("txn reset mid-ADD");

    // Directed instructions.
    run_instr(16'hA148, 0, lat); check_int("add_latency", lat, 5);
    run_instr(16'hD3FB, 0, lat); check_int("movimm_latency", lat, 2);
    run_instr(16'hA902, 2, lat);
    run_instr(16'hB885, 0, lat);
    run_instr(16'hC0B3, 1, lat);   // MOV R5,R3,LSR
    run_instr(16'h0000, 0, lat);   // illegal, one ERR cycle then IDLE
    run_instr(16'hC900, 0, lat);   // 110,01 illegal
    run_instr(16'hD800, 0, lat);   // 110,11 illegal

    // Random mix of legal and arbitrary encodings with random stalls.
    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r[15:11] = legal[$urandom_range(0, 5)];
      run_instr(r, 1, lat);
    end
    @(negedge clk);
    check_vec("idle_after_random", observe(), model(K_IDLE, model_ir));

    // No-stall, halting instance: step_ready is tied low and must be ignored.
    @(negedge clk);
    in_valid2 = 1'b1; instr2 = 16'hA148;
    @(posedge clk); #1 in_valid2 = 1'b0;
    cyc = 0; lat = -1;
    while (lat < 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (done2) lat = cyc;
    end
    check_int("nostall_add_latency", lat, 5);
    @(negedge clk);
    in_valid2 = 1'b1; instr2 = 16'hD3FB;
    @(posedge clk); #1 in_valid2 = 1'b0;
    @(negedge clk);
    check_int("narrow_sximm8", int'(sximm8_2), int'(12'hFFB));
    check_int("narrow_sximm5", int'(sximm5_2), int'(12'hFFB));
    @(negedge clk);
    check_int("nostall_movimm_done", int'(done2), 1);
    @(negedge clk);
    in_valid2 = 1'b1; instr2 = 16'h0000;
    @(posedge clk); #1 in_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_int("sticky_illegal", int'(illegal2), 1);
      check_int("sticky_not_ready", int'(in_ready2), 0);
    end
    reset = 1'b0;
    #1 check_int("illegal_cleared_by_reset", int'(illegal2), 0);
    check_int("ready_after_reset", int'(in_ready2), 1);
    @(negedge clk); reset = 1'b1;
    $display("txn halting instance: add, movimm, sticky illegal");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer_decoder.md
Name: instr_sequencer_decoder

Overview:
Parametrised successor to the combinational instruction decoder. Latches a 16-bit instruction through a valid/ready handshake and decodes its fields into registered state. A small FSM then steps the datapath through operand reads, execute and write-back, issuing readnum/writenum and the enables itself, so the controller no longer drives nsel. It sits between instruction fetch and the register-file/ALU datapath, and it flags illegal encodings.

Parameters:
DATA_W, 16, width of sign-extended immediates sximm5/sximm8; legal range >= 8.
STALL_EN, 1, 1: RD_A/RD_B/EXEC/WR advance only when step_ready=1; 0: step_ready is ignored and each state lasts exactly one cycle.
ILLEGAL_HALT, 0, 0: ERR lasts one cycle, then IDLE; 1: ERR is sticky until reset.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  instr is valid
in_ready  out  1  decoder can accept; equals (state==IDLE)
instr  in  16  {opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], shift[4:3], Rm[2:0]}; imm8=[7:0], imm5=[4:0]
step_ready  in  1  datapath accepts the current step
opcode  out  3  IR[15:13]
op  out  2  IR[12:11]
ALUop  out  2  IR[12:11]
shift  out  2  IR[4:3] for opcode 101 or (110,op 00); else 00
sximm5  out  DATA_W  sign-extended IR[4:0]
sximm8  out  DATA_W  sign-extended IR[7:0]
readnum  out  3  Rn in RD_A, Rm in RD_B, else 0
writenum  out  3  Rn for MOV-imm, else Rd, in WR; else 0
rd_en  out  1  high in RD_A/RD_B
rd_port  out  1  0 = load A (RD_A), 1 = load B (RD_B)
asel_zero  out  1  high in EXEC for MOV-reg and MVN (A operand forced to 0)
exec_en  out  1  high in EXEC (load C)
status_en  out  1  high in EXEC for CMP only
wr_en  out  1  high in WR
wr_src  out  1  1 = sximm8 (MOV-imm), 0 = C
done  out  1  one-cycle pulse in DONE
illegal  out  1  high in ERR

Behaviour:
- States: IDLE, RD_A, RD_B, EXEC, WR, DONE, ERR. Outputs are combinational from the state register and IR.
- Reset (asynchronous, reset==0): state=IDLE, IR=16'h0000. All enables, done and illegal are 0; readnum=writenum=0; in_ready=1. Reset mid-sequence aborts the sequence with no further enables.
- Accept: at a rising edge where in_valid & in_ready, IR<=instr and the state moves to the first step. instr is ignored outside IDLE.
- Sequences:
  - MOV-imm (110,10): WR -> DONE.
  - MOV-reg (110,00): RD_B -> EXEC -> WR -> DONE.
  - ADD (101,00) and AND (101,10): RD_A -> RD_B -> EXEC -> WR -> DONE.
  - CMP (101,01): RD_A -> RD_B -> EXEC -> DONE (no write).
  - MVN (101,11): RD_B -> EXEC -> WR -> DONE.
  - Any other opcode/op, including 110,01 and 110,11: ERR.
- Stall: with STALL_EN=1, RD_A/RD_B/EXEC/WR hold, with outputs stable, while step_ready=0. DONE and ERR never stall.
- DONE -> IDLE unconditionally. The next instruction can be accepted on the cycle after DONE; there is no back-to-back accept in DONE.
- Latency, accept edge to done, with no stalls: ADD = 5 cycles, MOV-imm = 2 cycles.
- Sign extension: sximm5 = {(DATA_W-5){IR[4]}, IR[4:0]}; sximm8 = {(DATA_W-8){IR[7]}, IR[7:0]}.
- Only one of rd_en, exec_en, wr_en is high in any cycle.

Test Plan:
1. Reset low mid-ADD (in EXEC) -> next cycle: state IDLE, in_ready=1, all enables 0, readnum=writenum=0.
2. Accept 0xA148 (ADD R2,R1,R0, LSL) with step_ready=1:
   - RD_A: readnum=1, rd_port=0.
   - RD_B: readnum=0, rd_port=1.
   - EXEC: exec_en=1, shift=01.
   - WR: writenum=2, wr_src=0.
   - DONE: done=1.
   - done is high exactly 5 cycles after the accept edge.
3. Accept 0xD3FB (MOV R3,#-5) -> WR: writenum=3, wr_src=1, sximm8=16'hFFFB; then done; shift=00.
4. Accept 0xA902 (CMP R1,R2) with step_ready low for 3 cycles in RD_B -> readnum=2 holds for those 3 cycles; EXEC: status_en=1; wr_en is never asserted.
5. Accept 0xB885 (MVN R4,R5) -> RD_B: readnum=5; EXEC: asel_zero=1; WR: writenum=4; RD_A is never entered.
6. Accept 0x0000:
   - ILLEGAL_HALT=0: illegal=1 for 1 cycle, then in_ready=1.
   - ILLEGAL_HALT=1: illegal stays 1 until reset.
